// File: rtl/rv_mem_arbiter.sv
// Fetch/data arbiter sharing one single-port synchronous memory.
// One access per cycle with a single-cycle response; fetch is protected from data starvation.
module rv_mem_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    output logic                  if_gnt_o,
    output logic                  if_rvalid_o,
    output logic [DATA_WIDTH-1:0] if_rdata_o,
    input  logic                  d_req_i,
    input  logic                  d_we_i,
    input  logic [3:0]            d_be_i,
    input  logic [ADDR_WIDTH-1:0] d_addr_i,
    input  logic [DATA_WIDTH-1:0] d_wdata_i,
    output logic                  d_gnt_o,
    output logic                  d_rvalid_o,
    output logic [DATA_WIDTH-1:0] d_rdata_o,
    output logic                  mem_en_o,
    output logic                  mem_we_o,
    output logic [3:0]            mem_be_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    // state  | meaning
    // IDLE   | no access was issued last cycle
    // RESP_I | fetch was granted last cycle, its data is on mem_rdata_i
    // RESP_D | data access was granted last cycle, read data or write ack due
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RESP_I = 2'd1,
        RESP_D = 2'd2
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_starve_cnt;
    logic       r_resp_we;
    logic       w_starved;
    logic       w_if_gnt;
    logic       w_d_gnt;

    always_comb begin
        w_starved = (r_starve_cnt == LIMIT);
        w_if_gnt  = 1'b0;
        w_d_gnt   = 1'b0;
        if (!rst) begin
            if (if_req_i && (!d_req_i || w_starved)) begin
                w_if_gnt = 1'b1;
            end else if (d_req_i) begin
                w_d_gnt = 1'b1;
            end
        end
    end

    assign if_gnt_o = w_if_gnt;
    assign d_gnt_o  = w_d_gnt;

    // Memory-side fields are forced to zero whenever nothing is granted.
    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'b0000;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (w_if_gnt) begin
            mem_en_o   = 1'b1;
            mem_addr_o = if_addr_i;
        end else if (w_d_gnt) begin
            mem_en_o    = 1'b1;
            mem_we_o    = d_we_i;
            mem_be_o    = d_be_i;
            mem_addr_o  = d_addr_i;
            mem_wdata_o = d_wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_starve_cnt <= 4'd0;
            r_resp_we    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (!if_req_i || w_if_gnt) begin
                r_starve_cnt <= 4'd0;
            end else if (w_d_gnt && (r_starve_cnt != LIMIT)) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end
            if (w_d_gnt) begin
                r_resp_we <= d_we_i;
            end
        end
    end

    // Responses are also masked during reset so an in-flight access is dropped.
    always_comb begin
        w_state_nxt = IDLE;
        if_rvalid_o = 1'b0;
        if_rdata_o  = '0;
        d_rvalid_o  = 1'b0;
        d_rdata_o   = '0;
        if (w_if_gnt) begin
            w_state_nxt = RESP_I;
        end else if (w_d_gnt) begin
            w_state_nxt = RESP_D;
        end
        case (r_state)
            RESP_I: begin
                if (!rst) begin
                    if_rvalid_o = 1'b1;
                    if_rdata_o  = mem_rdata_i;
                end
            end
            RESP_D: begin
                if (!rst) begin
                    d_rvalid_o = 1'b1;
                    d_rdata_o  = r_resp_we ? '0 : mem_rdata_i;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Self-checking bench for rv_mem_arbiter: per-cycle reference model with a
// response scoreboard, plus directed scenarios with fixed expected values.
module tb_rv_mem_arbiter;

    localparam int LIMIT = 4;

    logic        clk;
    logic        rst;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_gnt_o;
    logic        if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        d_req_i;
    logic        d_we_i;
    logic [3:0]  d_be_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic        d_gnt_o;
    logic        d_rvalid_o;
    logic [31:0] d_rdata_o;
    logic        mem_en_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;

    rv_mem_arbiter #(
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (32),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req_i   (if_req_i),
        .if_addr_i  (if_addr_i),
        .if_gnt_o   (if_gnt_o),
        .if_rvalid_o(if_rvalid_o),
        .if_rdata_o (if_rdata_o),
        .d_req_i    (d_req_i),
        .d_we_i     (d_we_i),
        .d_be_i     (d_be_i),
        .d_addr_i   (d_addr_i),
        .d_wdata_i  (d_wdata_i),
        .d_gnt_o    (d_gnt_o),
        .d_rvalid_o (d_rvalid_o),
        .d_rdata_o  (d_rdata_o),
        .mem_en_o   (mem_en_o),
        .mem_we_o   (mem_we_o),
        .mem_be_o   (mem_be_o),
        .mem_addr_o (mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    // Bench-owned memory contents.
    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    always @(posedge clk) begin
        if (mem_en_o && mem_we_o) begin
            logic [31:0] w;
            w = rd(mem_addr_o);
            for (int b = 0; b < 4; b++)
                if (mem_be_o[b]) w[8*b +: 8] = mem_wdata_o[8*b +: 8];
            mem[mem_addr_o] = w;
            mem_rdata_i <= 32'hA5A5_A5A5;
        end else if (mem_en_o) begin
            mem_rdata_i <= rd(mem_addr_o);
        end else begin
            mem_rdata_i <= 32'hA5A5_A5A5;
        end
    end

    typedef struct packed {
        logic        is_i;
        logic [31:0] data;
        int          due;
    } resp_t;

    resp_t sb[$];
    int    cyc      = 0;
    int    m_starve = 0;
    logic  g_if     = 1'b0;
    logic  g_d      = 1'b0;

    always @(negedge clk) begin
        logic        e_iv, e_dv, e_ig, e_dg;
        logic [31:0] e_ir, e_dr;
        resp_t       r;
        e_iv = 1'b0; e_dv = 1'b0; e_ir = 32'h0; e_dr = 32'h0;
        if (rst) sb.delete();
        if (sb.size() > 0 && sb[0].due == cyc) begin
            r = sb.pop_front();
            if (r.is_i) begin e_iv = 1'b1; e_ir = r.data; end
            else begin e_dv = 1'b1; e_dr = r.data; end
        end
        check("if_rvalid", 64'(if_rvalid_o), 64'(e_iv));
        check("if_rdata",  64'(if_rdata_o),  64'(e_ir));
        check("d_rvalid",  64'(d_rvalid_o),  64'(e_dv));
        check("d_rdata",   64'(d_rdata_o),   64'(e_dr));

        e_ig = !rst && if_req_i && (!d_req_i || m_starve == LIMIT);
        e_dg = !rst && d_req_i && !e_ig;
        check("if_gnt",    64'(if_gnt_o),    64'(e_ig));
        check("d_gnt",     64'(d_gnt_o),     64'(e_dg));
        check("mem_en",    64'(mem_en_o),    64'(e_ig | e_dg));
        check("mem_we",    64'(mem_we_o),    64'(e_dg & d_we_i));
        check("mem_be",    64'(mem_be_o),    64'(e_dg ? d_be_i : 4'b0));
        check("mem_addr",  64'(mem_addr_o),  64'(e_ig ? if_addr_i : (e_dg ? d_addr_i : 32'h0)));
        check("mem_wdata", 64'(mem_wdata_o), 64'(e_dg ? d_wdata_i : 32'h0));

        if (e_ig) sb.push_back('{is_i: 1'b1, data: rd(if_addr_i), due: cyc + 1});
        if (e_dg) sb.push_back('{is_i: 1'b0, data: (d_we_i ? 32'h0 : rd(d_addr_i)), due: cyc + 1});

        if (rst || !if_req_i || e_ig) m_starve = 0;
        else if (e_dg && m_starve < LIMIT) m_starve++;
        g_if = e_ig;
        g_d  = e_dg;
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [9:0] tr;
        int         nd;
        logic       i_act, d_act;

        mem[32'h100]  = 32'h0050_0093;
        mem[32'h104]  = 32'h00A0_0113;
        mem[32'h108]  = 32'h00B0_0193;
        mem[32'h2000] = 32'hCAFE_F00D;
        mem[32'h2004] = 32'h1122_3344;
        for (int k = 0; k < 8; k++) mem[32'h3000 + 32'(4*k)] = 32'h1000_0000 + 32'(k);

        rst = 1'b1; if_req_i = 1'b0; if_addr_i = 32'h0;
        d_req_i = 1'b0; d_we_i = 1'b0; d_be_i = 4'h0; d_addr_i = 32'h0; d_wdata_i = 32'h0;
        if_req_i = 1'b1; d_req_i = 1'b1;
        @(negedge clk);
        check("rst_no_gnt", 64'({if_gnt_o, d_gnt_o, mem_en_o}), 64'(0));
        if_req_i = 1'b0; d_req_i = 1'b0;
        repeat (3) step();
        rst = 1'b0;

        // idle
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("idle", 64'({mem_en_o, if_rvalid_o, d_rvalid_o}), 64'(0));
            step();
        end

        // lone fetch
        if_req_i = 1'b1; if_addr_i = 32'h100;
        @(negedge clk);
        check("lone_gnt", 64'(if_gnt_o), 64'(1));
        step();
        if_req_i = 1'b0;
        @(negedge clk);
        check("lone_rvalid", 64'(if_rvalid_o), 64'(1));
        check("lone_rdata",  64'(if_rdata_o),  64'(32'h0050_0093));
        step();

        // simultaneous fetch + data read
        if_req_i = 1'b1; if_addr_i = 32'h104;
        d_req_i = 1'b1; d_we_i = 1'b0; d_be_i = 4'hF; d_addr_i = 32'h2000;
        @(negedge clk);
        check("sim_c0", 64'({d_gnt_o, if_gnt_o}), 64'(2'b10));
        step();
        d_req_i = 1'b0;
        @(negedge clk);
        check("sim_c1", 64'({if_gnt_o, d_rvalid_o}), 64'(2'b11));
        check("sim_drdata", 64'(d_rdata_o), 64'(32'hCAFE_F00D));
        step();
        if_req_i = 1'b0;
        @(negedge clk);
        check("sim_c2", 64'({if_rvalid_o, d_rvalid_o}), 64'(2'b10));
        check("sim_irdata", 64'(if_rdata_o), 64'(32'h00A0_0113));
        step();

        // data write with partial byte enables, then read back
        d_req_i = 1'b1; d_we_i = 1'b1; d_be_i = 4'b0011; d_addr_i = 32'h2004; d_wdata_i = 32'hDEAD_BEEF;
        @(negedge clk);
        check("wr_mem", 64'({mem_en_o, mem_we_o, mem_be_o}), 64'(6'b11_0011));
        step();
        d_we_i = 1'b0; d_be_i = 4'hF; d_wdata_i = 32'h0;
        @(negedge clk);
        check("wr_ack", 64'({d_rvalid_o, d_rdata_o}), 64'({1'b1, 32'h0}));
        step();
        d_req_i = 1'b0;
        @(negedge clk);
        check("wr_readback", 64'(d_rdata_o), 64'(32'h1122_BEEF));
        step();

        // starvation guard
        if_req_i = 1'b1; if_addr_i = 32'h108;
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h3000;
        tr = '0; nd = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            tr = {tr[8:0], if_gnt_o};
            nd += int'(d_gnt_o);
            step();
        end
        if_req_i = 1'b0; d_req_i = 1'b0;
        check("starve_pattern", 64'(tr), 64'(10'b00001_00001));
        check("starve_dcount",  64'(nd), 64'(8));
        step();

        // reset with a fetch outstanding
        if_req_i = 1'b1; if_addr_i = 32'h100;
        @(negedge clk);
        check("rst_pre_gnt", 64'(if_gnt_o), 64'(1));
        step();
        rst = 1'b1; if_req_i = 1'b0; d_req_i = 1'b1; d_addr_i = 32'h2000;
        @(negedge clk);
        check("rst_drop", 64'({if_rvalid_o, d_gnt_o, mem_en_o}), 64'(0));
        step();
        rst = 1'b0; d_req_i = 1'b0; if_req_i = 1'b1; if_addr_i = 32'h104;
        @(negedge clk);
        check("rst_idle", 64'({if_rvalid_o, d_rvalid_o}), 64'(0));
        check("rst_first_gnt", 64'(if_gnt_o), 64'(1));
        step();
        if_req_i = 1'b0;
        @(negedge clk);
        check("rst_post_rdata", 64'(if_rdata_o), 64'(32'h00A0_0113));
        step();

        // random traffic with hold-until-grant requesters
        i_act = 1'b0; d_act = 1'b0;
        for (int k = 0; k < 80; k++) begin
            if (g_if) i_act = 1'b0;
            if (g_d)  d_act = 1'b0;
            if (!i_act && $urandom_range(0, 1) == 1) begin
                i_act = 1'b1;
                if_addr_i = 32'h3000 + 32'(4 * $urandom_range(0, 7));
            end
            if (!d_act && $urandom_range(0, 2) != 0) begin
                d_act = 1'b1;
                d_we_i = 1'($urandom_range(0, 1));
                d_be_i = 4'($urandom_range(0, 15));
                d_addr_i = 32'h3000 + 32'(4 * $urandom_range(0, 7));
                d_wdata_i = $urandom;
            end
            if_req_i = i_act;
            d_req_i  = d_act;
            step();
        end
        if_req_i = 1'b0; d_req_i = 1'b0;
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
